// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for a 5-stage RISC-V pipeline.
// Produces EX/ID forwarding selects, detects load-use and branch-dependency
// hazards, sequences multi-cycle mul/div occupancy of EX and arbitrates the
// stall/bubble/flush controls. It also keeps a saturating stall-cycle counter.
module hazard_forward_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_branch,
  input  logic              id_jalr,
  input  logic              id_redirect,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic              ex_muldiv,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              mem_stall,
  input  logic              cnt_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [1:0]        id_fwd_a,
  output logic [1:0]        id_fwd_b,
  output logic              stall_pc,
  output logic              stall_ifid,
  output logic              stall_idex,
  output logic              stall_exmem,
  output logic              stall_memwb,
  output logic              bubble_idex,
  output logic              bubble_exmem,
  output logic              flush_ifid,
  output logic              muldiv_busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Down-counter is at least 3 bits wide, wider for long latencies.
  localparam int MCW     = ($clog2(MULDIV_LAT) > 3) ? $clog2(MULDIV_LAT) : 3;
  localparam int MD_LOAD = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_e;

  md_state_e        state_q, state_d;
  logic [MCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic md_hold_s;
  logic busy_s;
  logic load_use_s;
  logic br_haz_s;
  logic need_rs1_s;
  logic need_rs2_s;

  // Producer rd feeds consumer rs when it writes a non-zero register.
  function automatic logic rmatch(input logic [REG_AW-1:0] rd,
                                  input logic [REG_AW-1:0] rs,
                                  input logic              we);
    return we && (rd != {REG_AW{1'b0}}) && (rd == rs);
  endfunction

  // EX operand select: EX/MEM result wins over MEM/WB result.
  function automatic logic [1:0] ex_sel(input logic [REG_AW-1:0] rs);
    if (rmatch(mem_rd, rs, mem_regwrite)) begin
      return 2'b10;
    end else if (rmatch(wb_rd, rs, wb_regwrite)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // ID compare select: a load in MEM has no data yet, so it never forwards.
  function automatic logic [1:0] id_sel(input logic [REG_AW-1:0] rs,
                                        input logic              need);
    if (need && rmatch(mem_rd, rs, mem_regwrite) && !mem_memread) begin
      return 2'b10;
    end else if (need && rmatch(wb_rd, rs, wb_regwrite)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  // Forwarding selects for the EX operands and the ID branch/jalr compare.
  always_comb begin
    need_rs1_s = id_branch || id_jalr;
    need_rs2_s = id_branch;
    fwd_a      = ex_sel(ex_rs1);
    fwd_b      = ex_sel(ex_rs2);
    id_fwd_a   = id_sel(id_rs1, need_rs1_s);
    id_fwd_b   = id_sel(id_rs2, need_rs2_s);
  end

  // Load-use and branch-dependency hazard detection.
  always_comb begin
    load_use_s = ex_memread && ex_regwrite && (ex_rd != {REG_AW{1'b0}}) &&
                 ((id_use_rs1 && (ex_rd == id_rs1)) ||
                  (id_use_rs2 && (ex_rd == id_rs2)));
    br_haz_s   = (need_rs1_s && (rmatch(ex_rd, id_rs1, ex_regwrite) ||
                                 rmatch(mem_rd, id_rs1, mem_regwrite && mem_memread))) ||
                 (need_rs2_s && (rmatch(ex_rd, id_rs2, ex_regwrite) ||
                                 rmatch(mem_rd, id_rs2, mem_regwrite && mem_memread)));
  end

  // Mul/div FSM state and occupancy counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= {MCW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Mul/div next state; a memory stall freezes the sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mem_stall) begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ex_muldiv && (MULDIV_LAT > 1)) begin
            state_d = S_BUSY;
            cnt_d   = MCW'(MD_LOAD);
          end else begin
            state_d = S_IDLE;
          end
        end
        S_BUSY: begin
          if (cnt_q != {MCW{1'b0}}) begin
            cnt_d = cnt_q - MCW'(1);
          end else begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = {MCW{1'b0}};
        end
      endcase
    end
  end

  // Mul/div outputs: busy marks the BUSY cycles that still hold EX.
  always_comb begin
    md_hold_s = 1'b0;
    busy_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        md_hold_s = ex_muldiv && (MULDIV_LAT > 1);
        busy_s    = 1'b0;
      end
      S_BUSY: begin
        md_hold_s = (cnt_q != {MCW{1'b0}});
        busy_s    = (cnt_q != {MCW{1'b0}});
      end
      default: begin
        md_hold_s = 1'b0;
        busy_s    = 1'b0;
      end
    endcase
    muldiv_busy = busy_s;
  end

  // Pipeline control arbitration; a redirect only acts when nothing stalls.
  always_comb begin
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idex   = 1'b0;
    stall_exmem  = 1'b0;
    stall_memwb  = 1'b0;
    bubble_idex  = 1'b0;
    bubble_exmem = 1'b0;
    flush_ifid   = 1'b0;
    if (mem_stall) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      stall_memwb = 1'b1;
    end else if (md_hold_s) begin
      stall_pc     = 1'b1;
      stall_ifid   = 1'b1;
      stall_idex   = 1'b1;
      bubble_exmem = 1'b1;
    end else if (load_use_s || br_haz_s) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      bubble_idex = 1'b1;
    end else if (id_redirect) begin
      flush_ifid = 1'b1;
    end else begin
      flush_ifid = 1'b0;
    end
  end

  // Stall counter next value: clear wins, then saturating increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = {CNT_W{1'b0}};
    end else if (!mem_stall && (md_hold_s || load_use_s || br_haz_s) &&
                 (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: directed vectors push expected
// outputs into queues, a negedge monitor pops and compares.
module tb_hazard_forward_ctrl;

  localparam int AW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_use_rs1, id_use_rs2, id_branch, id_jalr, id_redirect;
  logic          ex_regwrite, ex_memread, ex_muldiv;
  logic          mem_regwrite, mem_memread, wb_regwrite, mem_stall, cnt_clr;
  logic [1:0]    fwd_a, fwd_b, id_fwd_a, id_fwd_b;
  logic          stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic          bubble_idex, bubble_exmem, flush_ifid, muldiv_busy;
  logic [CW-1:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  string         nq[$];
  logic [16:0]   cq[$];
  logic [CW-1:0] kq[$];

  hazard_forward_ctrl #(.REG_AW(AW), .MULDIV_LAT(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_branch(id_branch), .id_jalr(id_jalr), .id_redirect(id_redirect),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_muldiv(ex_muldiv),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .mem_stall(mem_stall), .cnt_clr(cnt_clr),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .id_fwd_a(id_fwd_a), .id_fwd_b(id_fwd_b),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
    .bubble_idex(bubble_idex), .bubble_exmem(bubble_exmem),
    .flush_ifid(flush_ifid), .muldiv_busy(muldiv_busy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Expected control word: {fwd_a,fwd_b,id_fwd_a,id_fwd_b, stalls[5], bubbles[2], flush, busy}
  function automatic logic [16:0] ctl(input logic [7:0] fw, input logic [4:0] st,
                                      input logic [1:0] bb, input logic fl, input logic bz);
    return {fw, st, bb, fl, bz};
  endfunction

  localparam logic [4:0] ST_LU = 5'b11000;
  localparam logic [4:0] ST_MD = 5'b11100;
  localparam logic [4:0] ST_MS = 5'b11111;

  task automatic clr();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_branch = 1'b0; id_jalr = 1'b0; id_redirect = 1'b0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_muldiv = 1'b0;
    mem_regwrite = 1'b0; mem_memread = 1'b0; wb_regwrite = 1'b0;
    mem_stall = 1'b0; cnt_clr = 1'b0;
  endtask

  // Queue the expectation for the current inputs, then advance one cycle.
  task automatic cyc(input string nm, input logic [16:0] ec, input logic [CW-1:0] en);
    nq.push_back(nm);
    cq.push_back(ec);
    kq.push_back(en);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  always @(negedge clk) begin
    if (cq.size() > 0) begin
      string         nm;
      logic [16:0]   ec;
      logic [16:0]   ac;
      logic [CW-1:0] en;
      nm = nq.pop_front();
      ec = cq.pop_front();
      en = kq.pop_front();
      ac = {fwd_a, fwd_b, id_fwd_a, id_fwd_b, stall_pc, stall_ifid, stall_idex,
            stall_exmem, stall_memwb, bubble_idex, bubble_exmem, flush_ifid, muldiv_busy};
      n_cmp = n_cmp + 1;
      if (ac !== ec) begin
        n_err = n_err + 1;
        $display("FAIL %s ctrl: got %b expected %b", nm, ac, ec);
      end
      n_cmp = n_cmp + 1;
      if (stall_cnt !== en) begin
        n_err = n_err + 1;
        $display("FAIL %s stall_cnt: got %0d expected %0d", nm, stall_cnt, en);
      end
    end
  end

  initial begin
    clr();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", 17'd0, 4'd0);
    rst = 1'b0;
    cyc("post_reset", 17'd0, 4'd0);

    // EX forwarding priority and x0 suppression
    ex_rd = 5'd5; ex_rs1 = 5'd5; mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1;
    cyc("fwd_exmem", ctl(8'b10_00_00_00, 5'b0, 2'b0, 1'b0, 1'b0), 4'd0);
    mem_regwrite = 1'b0;
    cyc("fwd_memwb", ctl(8'b01_00_00_00, 5'b0, 2'b0, 1'b0, 1'b0), 4'd0);
    mem_rd = 5'd0; wb_rd = 5'd0; mem_regwrite = 1'b1;
    cyc("fwd_x0", ctl(8'b00_00_00_00, 5'b0, 2'b0, 1'b0, 1'b0), 4'd0);
    ex_rs1 = 5'd3; ex_rs2 = 5'd9; mem_rd = 5'd9; wb_rd = 5'd3;
    cyc("fwd_both", ctl(8'b01_10_00_00, 5'b0, 2'b0, 1'b0, 1'b0), 4'd0);

    // Load-use stall with a redirect that must be ignored, then honoured
    clr();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; id_redirect = 1'b1;
    cyc("load_use", ctl(8'b0, ST_LU, 2'b10, 1'b0, 1'b0), 4'd0);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_rd = 5'd7; mem_regwrite = 1'b1; mem_memread = 1'b1;
    cyc("redirect", ctl(8'b0, 5'b0, 2'b0, 1'b1, 1'b0), 4'd1);

    // Load then branch on x7: two stalls, then WB forward
    clr();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd7; id_branch = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    cyc("ld_br_1", ctl(8'b0, ST_LU, 2'b10, 1'b0, 1'b0), 4'd1);
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_rd = 5'd7; mem_regwrite = 1'b1; mem_memread = 1'b1;
    cyc("ld_br_2", ctl(8'b0, ST_LU, 2'b10, 1'b0, 1'b0), 4'd2);
    mem_rd = 5'd0; mem_regwrite = 1'b0; mem_memread = 1'b0; wb_rd = 5'd7; wb_regwrite = 1'b1;
    cyc("ld_br_fwd", ctl(8'b00_00_01_00, 5'b0, 2'b0, 1'b0, 1'b0), 4'd3);

    // ALU then branch: one stall, then EX/MEM forward
    clr();
    ex_regwrite = 1'b1; ex_rd = 5'd7; id_branch = 1'b1; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    cyc("alu_br_1", ctl(8'b0, ST_LU, 2'b10, 1'b0, 1'b0), 4'd3);
    ex_regwrite = 1'b0; ex_rd = 5'd0; mem_rd = 5'd7; mem_regwrite = 1'b1;
    cyc("alu_br_fwd", ctl(8'b00_00_10_00, 5'b0, 2'b0, 1'b0, 1'b0), 4'd4);
    // jalr never needs rs2
    clr();
    id_jalr = 1'b1; id_rs2 = 5'd7; mem_rd = 5'd7; mem_regwrite = 1'b1;
    cyc("jalr_rs2", ctl(8'b0, 5'b0, 2'b0, 1'b0, 1'b0), 4'd4);

    // Mul/div pulse, latency 4
    clr();
    ex_muldiv = 1'b1;
    cyc("md_0", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b0), 4'd4);
    ex_muldiv = 1'b0;
    cyc("md_1", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b1), 4'd5);
    cyc("md_2", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b1), 4'd6);
    cyc("md_3", ctl(8'b0, 5'b0, 2'b0, 1'b0, 1'b0), 4'd7);
    cyc("md_idle", ctl(8'b0, 5'b0, 2'b0, 1'b0, 1'b0), 4'd7);

    // Memory stall while BUSY at cnt=1
    ex_muldiv = 1'b1;
    cyc("ms_0", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b0), 4'd7);
    ex_muldiv = 1'b0;
    cyc("ms_1", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b1), 4'd8);
    mem_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc("ms_frozen", ctl(8'b0, ST_MS, 2'b0, 1'b0, 1'b1), 4'd9);
    end
    mem_stall = 1'b0;
    cyc("ms_resume", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b1), 4'd9);
    cyc("ms_done", ctl(8'b0, 5'b0, 2'b0, 1'b0, 1'b0), 4'd10);
    cyc("ms_idle", ctl(8'b0, 5'b0, 2'b0, 1'b0, 1'b0), 4'd10);

    // Back-to-back mul/div, then reset mid-BUSY
    ex_muldiv = 1'b1;
    cyc("b2b_0", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b0), 4'd10);
    cyc("b2b_1", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b1), 4'd11);
    cyc("b2b_2", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b1), 4'd12);
    cyc("b2b_3", ctl(8'b0, 5'b0, 2'b0, 1'b0, 1'b0), 4'd13);
    cyc("b2b_next", ctl(8'b0, ST_MD, 2'b01, 1'b0, 1'b0), 4'd13);
    ex_muldiv = 1'b0; rst = 1'b1;
    cyc("rst_busy", 17'd0, 4'd0);
    rst = 1'b0;
    cyc("rst_idle", 17'd0, 4'd0);

    // Saturation, then clear beats a pending increment
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    for (int i = 0; i < 18; i++) begin
      cyc("saturate", ctl(8'b0, ST_LU, 2'b10, 1'b0, 1'b0), (i > 15) ? 4'd15 : 4'(i));
    end
    cnt_clr = 1'b1;
    cyc("clr_hit", ctl(8'b0, ST_LU, 2'b10, 1'b0, 1'b0), 4'd15);
    clr();
    cyc("clr_done", 17'd0, 4'd0);

    for (int i = 0; i < 10 && cq.size() > 0; i++) begin
      @(negedge clk);
    end
    if (cq.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_err = n_err + 1;
      $display("FAIL drain: got %0d pending expected 0", cq.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
